// File: rtl/sn76489_bus_ctrl.sv
// SN76489 host write controller: captures CE/WE bus bytes, decodes latch/data bytes against the
// register latch, issues one clk_en-qualified channel write strobe and holds READY low while busy.
module sn76489_bus_ctrl #(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic       clock_i,
    input  logic       res_n_i,
    input  logic       clk_en_i,
    input  logic       ce_n_i,
    input  logic       we_n_i,
    input  logic [0:7] d_i,
    output logic       ready_o,
    output logic [0:7] d_o,
    output logic       r2_o,
    output logic [0:3] we_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStrobe = 2'd1;
    localparam logic [1:0] StBusy   = 2'd2;

    localparam logic [7:0] CntInit = 8'(READY_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic       access_q, access_d;
    logic [0:7] data_q, data_d;
    logic [1:0] ch_q, ch_d;
    logic       r2_q, r2_d;
    logic [1:0] latch_ch_q, latch_ch_d;
    logic       latch_r2_q, latch_r2_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;

    logic access;
    logic new_access;

    assign access     = ~ce_n_i & ~we_n_i;
    assign new_access = access & ~access_q;

    always_comb begin
        state_d    = state_q;
        access_d   = access;
        data_d     = data_q;
        ch_d       = ch_q;
        r2_d       = r2_q;
        latch_ch_d = latch_ch_q;
        latch_r2_d = latch_r2_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;

        case (state_q)
            StIdle: begin
                if (new_access) begin
                    data_d  = d_i;
                    ready_d = 1'b0;
                    state_d = StStrobe;
                    // Decode is resolved at capture; the latch cannot change until the strobe ends.
                    if (d_i[0]) begin
                        ch_d = d_i[1:2];
                        r2_d = d_i[3];
                    end else begin
                        ch_d = latch_ch_q;
                        r2_d = latch_r2_q;
                    end
                end
            end
            StStrobe: begin
                if (clk_en_i) begin
                    if (data_q[0]) begin
                        latch_ch_d = ch_q;
                        latch_r2_d = r2_q;
                    end
                    if (READY_CYCLES == 1) begin
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (clk_en_i) begin
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q    <= StIdle;
            access_q   <= 1'b0;
            data_q     <= '0;
            ch_q       <= 2'd0;
            r2_q       <= 1'b0;
            latch_ch_q <= 2'd0;
            latch_r2_q <= 1'b0;
            cnt_q      <= 8'd0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            access_q   <= access_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            r2_q       <= r2_d;
            latch_ch_q <= latch_ch_d;
            latch_r2_q <= latch_r2_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
        end
    end

    // Strobe comes from registered state only, so it is stable across the whole STROBE state.
    always_comb begin
        we_o = 4'b0000;
        if (state_q == StStrobe) begin
            we_o[ch_q] = 1'b1;
        end
    end

    assign ready_o = ready_q;
    assign d_o     = data_q;
    assign r2_o    = r2_q;

endmodule

// File: tb/tb_sn76489_bus_ctrl.sv
// Directed bench for sn76489_bus_ctrl: writes bytes on the host bus and checks routing, d_o,
// strobe count and READY low time in clk_en ticks.
module tb_sn76489_bus_ctrl;

    logic       clock_i  = 1'b0;
    logic       res_n_i  = 1'b0;
    logic       clk_en_i = 1'b0;
    logic       ce_n_i   = 1'b1;
    logic       we_n_i   = 1'b1;
    logic [0:7] d_i      = '0;
    logic       ready_o;
    logic [0:7] d_o;
    logic       r2_o;
    logic [0:3] we_o;

    int checks    = 0;
    int failures  = 0;
    int div       = 0;
    int strobes   = 0;
    int low_ticks = 0;

    logic [0:3] we_s    = '0;
    logic [0:3] last_we = '0;
    logic       r2_s    = 1'b0;
    logic       last_r2 = 1'b0;
    logic       ready_s = 1'b1;

    sn76489_bus_ctrl #(
        .READY_CYCLES(32)
    ) dut (
        .clock_i (clock_i),
        .res_n_i (res_n_i),
        .clk_en_i(clk_en_i),
        .ce_n_i  (ce_n_i),
        .we_n_i  (we_n_i),
        .d_i     (d_i),
        .ready_o (ready_o),
        .d_o     (d_o),
        .r2_o    (r2_o),
        .we_o    (we_o)
    );

    always #5 clock_i = ~clock_i;

    // Values sampled at the previous negedge are what the DUT saw at the posedge just passed.
    always @(negedge clock_i) begin
        if (clk_en_i) begin
            if (we_s != 4'b0000) begin
                strobes = strobes + 1;
                last_we = we_s;
                last_r2 = r2_s;
            end
            if (!ready_s) low_ticks = low_ticks + 1;
        end
        we_s     = we_o;
        r2_s     = r2_o;
        ready_s  = ready_o;
        div      = (div + 1) % 16;
        clk_en_i = (div == 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_write(input logic [7:0] b);
        @(negedge clock_i);
        strobes   = 0;
        low_ticks = 0;
        d_i       = b;
        ce_n_i    = 1'b0;
        we_n_i    = 1'b0;
        @(negedge clock_i);
        check("ready low after capture", 32'(ready_o), 32'd0);
    endtask

    task automatic end_access();
        @(negedge clock_i);
        ce_n_i = 1'b1;
        we_n_i = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready_o !== 1'b1 && n < 2000) begin
            @(negedge clock_i);
            n++;
        end
        check({tag, " ready timeout"}, 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clock_i);
    endtask

    task automatic verify(input string tag, input logic [7:0] d, input logic [3:0] we,
                          input logic r2);
        check({tag, " d_o"}, 32'(d_o), 32'(d));
        check({tag, " strobes"}, 32'(strobes), 32'd1);
        check({tag, " we_o"}, 32'(last_we), 32'(we));
        check({tag, " r2_o"}, 32'(last_r2), 32'(r2));
    endtask

    task automatic do_write(input string tag, input logic [7:0] b, input logic [3:0] we,
                            input logic r2);
        start_write(b);
        end_access();
        wait_ready(tag);
        verify(tag, b, we, r2);
    endtask

    initial begin
        int n;
        // Reset, inputs idle, clk_en toggling
        repeat (20) @(negedge clock_i);
        check("rst ready_o", 32'(ready_o), 32'd1);
        check("rst we_o", 32'(we_o), 32'd0);
        check("rst d_o", 32'(d_o), 32'd0);
        check("rst r2_o", 32'(r2_o), 32'd0);
        res_n_i = 1'b1;
        repeat (40) @(negedge clock_i);
        check("idle ready_o", 32'(ready_o), 32'd1);
        check("idle we_o", 32'(we_o), 32'd0);
        check("idle d_o", 32'(d_o), 32'd0);
        check("idle r2_o", 32'(r2_o), 32'd0);

        // Latch byte to tone1, READY low time counted in clk_en ticks
        do_write("w8F", 8'h8F, 4'b1000, 1'b0);
        check("w8F low ticks", 32'(low_ticks), 32'd32);

        // Noise latch then data byte routed via the latch
        do_write("wE5", 8'hE5, 4'b0001, 1'b0);
        do_write("w3F", 8'h3F, 4'b0001, 1'b0);
        check("w3F low ticks", 32'(low_ticks), 32'd32);

        // Noise attenuator latch then data byte
        do_write("wFF", 8'hFF, 4'b0001, 1'b1);
        do_write("w0A", 8'h0A, 4'b0001, 1'b1);

        // Access while busy is ignored, held access does not retrigger
        start_write(8'hB3);
        end_access();
        repeat (40) @(negedge clock_i);
        d_i    = 8'h90;
        ce_n_i = 1'b0;
        we_n_i = 1'b0;
        wait_ready("wB3");
        repeat (60) @(negedge clock_i);
        verify("wB3", 8'hB3, 4'b0100, 1'b1);
        check("wB3 low ticks", 32'(low_ticks), 32'd32);
        check("wB3 ready held", 32'(ready_o), 32'd1);
        end_access();
        repeat (4) @(negedge clock_i);
        do_write("w90", 8'h90, 4'b1000, 1'b1);

        // Reset during BUSY clears latch and outputs immediately
        start_write(8'hDF);
        end_access();
        n = 0;
        while (strobes == 0 && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        check("wDF strobe seen", 32'(n < 200), 32'd1);
        check("wDF we_o", 32'(last_we), 32'(4'b0010));
        repeat (40) @(negedge clock_i);
        check("wDF busy", 32'(ready_o), 32'd0);
        res_n_i = 1'b0;
        #1;
        check("mid rst ready_o", 32'(ready_o), 32'd1);
        check("mid rst we_o", 32'(we_o), 32'd0);
        check("mid rst d_o", 32'(d_o), 32'd0);
        check("mid rst r2_o", 32'(r2_o), 32'd0);
        repeat (5) @(negedge clock_i);
        res_n_i = 1'b1;
        repeat (60) @(negedge clock_i);
        check("post rst no strobe", 32'(strobes), 32'd1);
        check("post rst ready_o", 32'(ready_o), 32'd1);
        do_write("w05", 8'h05, 4'b1000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
